// File: rtl/aes128_pkg.sv
// Shared constants and FSM state type for the AES-128 output buffer slice.
package aes128_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_BATCH  = 8;
  localparam int AES_SLOT_W = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CAPT       = 2'd1,
    DRAIN_WAIT = 2'd2
  } out_buf_state_t;

endpackage

// File: rtl/aes128_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module aes128_sync_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] level_nxt_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          pop;
  logic          push_ok;

  // Next-state for pointers, occupancy and the registered head word.
  always_comb begin
    pop      = valid_q & pop_i;
    push_ok  = push_i & ((level_q != LW'(DEPTH)) | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    valid_d  = (level_d != '0);
    head_d   = head_q;
    // Head reloads only when it leaves or the FIFO was empty; the word just
    // being written is bypassed when nothing older remains behind the head.
    if ((pop | ~valid_q) & valid_d) begin
      if (level_q == LW'(pop)) begin
        head_d = din_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else begin
      head_d = head_q;
    end
  end

  // Control state and head register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign valid_o     = valid_q;
  assign dout_o      = head_q;
  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign drop_o      = push_i & ~push_ok;

endmodule

// File: rtl/aes128_out_buf.sv
// Output capture buffer behind the 8-way interleaved AES-128 core.
// Define AES_OUT_BUF_TAG_EN to store the interleave slot per entry and expose M_TAG.
module aes128_out_buf
  import aes128_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BATCH = AES_BATCH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DONE,
  input  logic [AES_BLK_W-1:0]   DOUT,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic [AES_BLK_W-1:0]   M_DATA,
`ifdef AES_OUT_BUF_TAG_EN
  output logic [AES_SLOT_W-1:0]  M_TAG,
`endif
  output logic                   ROOM,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] LEVEL
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef AES_OUT_BUF_TAG_EN
  localparam int WORD_W = AES_BLK_W + AES_SLOT_W;
`else
  localparam int WORD_W = AES_BLK_W;
`endif

  out_buf_state_t        state_q, state_d;
  logic [AES_SLOT_W-1:0] slot_q, slot_d;
  logic                  room_q, room_d;
  logic                  ovf_q, ovf_d;
  logic [WORD_W-1:0]     fifo_din;
  logic [WORD_W-1:0]     fifo_dout;
  logic [LVL_W-1:0]      level_nxt;
  logic                  fifo_drop;

`ifdef AES_OUT_BUF_TAG_EN
  assign fifo_din = {slot_q, DOUT};
`else
  assign fifo_din = DOUT;
`endif

  aes128_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (DONE),
    .din_i       (fifo_din),
    .pop_i       (M_READY),
    .valid_o     (M_VALID),
    .dout_o      (fifo_dout),
    .level_o     (LEVEL),
    .level_nxt_o (level_nxt),
    .drop_o      (fifo_drop)
  );

  // Batch FSM, slot counter, ROOM and sticky overflow next-state.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (DONE) begin
      slot_d = (slot_q == AES_SLOT_W'(BATCH - 1)) ? '0 : slot_q + AES_SLOT_W'(1);
    end else begin
      slot_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (DONE) state_d = CAPT;
        else      state_d = IDLE;
      end
      // Slot 0 seen again inside CAPT means a full batch already went by.
      CAPT: begin
        if (!DONE)                state_d = IDLE;
        else if (slot_q == '0)    state_d = DRAIN_WAIT;
        else                      state_d = CAPT;
      end
      DRAIN_WAIT: begin
        if (!DONE) state_d = IDLE;
        else       state_d = DRAIN_WAIT;
      end
      default: state_d = IDLE;
    endcase
    room_d = (state_d == IDLE) &&
             ((LVL_W'(DEPTH) - level_nxt) >= LVL_W'(BATCH));
    ovf_d  = ovf_q | fifo_drop;
  end

  // Registered control state and status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      slot_q  <= '0;
      room_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      room_q  <= room_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef AES_OUT_BUF_TAG_EN
  assign M_TAG  = fifo_dout[WORD_W-1:AES_BLK_W];
`endif
  assign M_DATA = fifo_dout[AES_BLK_W-1:0];
  assign ROOM   = room_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_aes128_out_buf.sv
// Randomized bench for aes128_out_buf against a queue-based reference model.
module tb_aes128_out_buf;

  typedef struct packed {
    logic [2:0]   tag;
    logic [127:0] data;
  } ent_t;

  logic         CLK;
  logic         RST;
  logic         DONE;
  logic [127:0] DOUT;
  logic         M_VALID;
  logic         M_READY;
  logic [127:0] M_DATA;
`ifdef AES_OUT_BUF_TAG_EN
  logic [2:0]   M_TAG;
`endif
  logic         ROOM;
  logic         OVF;
  logic [4:0]   LEVEL;

  aes128_out_buf #(.DEPTH(16), .BATCH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DONE    (DONE),
    .DOUT    (DOUT),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .M_DATA  (M_DATA),
`ifdef AES_OUT_BUF_TAG_EN
    .M_TAG   (M_TAG),
`endif
    .ROOM    (ROOM),
    .OVF     (OVF),
    .LEVEL   (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  ent_t q[$];
  int   beat;
  bit   ovf_m;
  bit   room_m;
  bit   head_zero;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    q.delete();
    beat      = 0;
    ovf_m     = 1'b0;
    room_m    = 1'b1;
    head_zero = 1'b1;
  endtask

  // One clock edge of the reference: pop first, then the push decision.
  task automatic model_edge(input logic done, input logic [127:0] d, input logic rdy);
    bit   do_pop;
    bit   was_full;
    ent_t e;
    do_pop   = (q.size() != 0) && rdy;
    was_full = (q.size() >= 16);
    if (do_pop) void'(q.pop_front());
    if (done) begin
      e.tag  = 3'(beat % 8);
      e.data = d;
      beat++;
      if (!was_full || do_pop) begin
        q.push_back(e);
        head_zero = 1'b0;
      end else begin
        ovf_m = 1'b1;
      end
    end else begin
      beat = 0;
    end
    room_m = !done && ((16 - q.size()) >= 8);
  endtask

  task automatic check_outputs();
    check_eq("valid", M_VALID, (q.size() != 0));
    check_eq("level", LEVEL, q.size());
    check_eq("room", ROOM, room_m);
    check_eq("ovf", OVF, ovf_m);
    if (q.size() != 0) begin
      check_eq("data", M_DATA, q[0].data);
`ifdef AES_OUT_BUF_TAG_EN
      check_eq("tag", M_TAG, q[0].tag);
`endif
    end else if (head_zero) begin
      check_eq("data_rst", M_DATA, 128'd0);
`ifdef AES_OUT_BUF_TAG_EN
      check_eq("tag_rst", M_TAG, 3'd0);
`endif
    end
  endtask

  task automatic step(input logic done, input logic [127:0] d, input logic rdy);
    DONE    = done;
    DOUT    = d;
    M_READY = rdy;
    @(posedge CLK);
    model_edge(done, d, rdy);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_rst();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    RST = 1'b0;
  endtask

  task automatic batch(input int n, input logic rdy, input int base);
    for (int i = 0; i < n; i++) step(1'b1, 128'(base + i), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rnd128(), rdy);
  endtask

  int run_left;
  bit d_r;

  initial begin
    RST     = 1'b1;
    DONE    = 1'b0;
    DOUT    = '0;
    M_READY = 1'b0;
    model_reset();
    #3;
    check_outputs();
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Single batch streamed straight through
    batch(8, 1'b1, 0);
    idle(3, 1'b1);

    // Two batches with a stalled consumer, then an overflowing beat
    batch(8, 1'b0, 16'h100);
    idle(1, 1'b0);
    batch(8, 1'b0, 16'h200);
    idle(1, 1'b0);
    batch(1, 1'b0, 16'h300);
    idle(1, 1'b0);
    idle(20, 1'b1);

    // Push and pop together on a full FIFO
    pulse_rst();
    batch(8, 1'b0, 16'h400);
    idle(1, 1'b0);
    batch(8, 1'b0, 16'h500);
    step(1'b1, 128'h600, 1'b1);
    idle(1, 1'b0);
    idle(18, 1'b1);

    // Over-long DONE run wraps the slot and passes through DRAIN_WAIT
    batch(10, 1'b1, 16'h700);
    idle(3, 1'b1);
    batch(8, 1'b0, 16'h780);
    idle(10, 1'b1);

    // Reset in the middle of a batch, remaining beats restart at slot 0
    batch(4, 1'b0, 16'h800);
    pulse_rst();
    batch(3, 1'b0, 16'h900);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Random DONE runs and random consumer backpressure
    pulse_rst();
    run_left = 0;
    for (int c = 0; c < 400; c++) begin
      if (run_left == 0 && $urandom_range(0, 3) == 0) run_left = $urandom_range(1, 12);
      d_r = (run_left > 0);
      if (d_r) run_left--;
      step(d_r, rnd128(), ($urandom_range(0, 2) != 0));
    end
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
